// File: rtl/arith_pkg.sv
// arith_pkg: shared widths, saturation limits and accumulator state encoding
package arith_pkg;
  localparam int WIDTH = 25;
  localparam int CNT_W = 8;
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {WIDTH-1{1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {WIDTH-1{1'b0}}};
  typedef enum logic {ACC = 1'b0, DONE = 1'b1} state_e;
endpackage

// File: rtl/sat_accumulator_if.sv
// sat_accumulator_if: sample-in and result-out valid/ready handshakes
interface sat_accumulator_if import arith_pkg::*; #(
  parameter int WIDTH = arith_pkg::WIDTH,
  parameter int CNT_W = arith_pkg::CNT_W
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_sat;
  logic [CNT_W-1:0] out_count;
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_sat, out_count
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_sat, out_count
  );
endinterface

// File: rtl/sat_accumulator_adder.sv
// sat_accumulator_adder: Kogge-Stone parallel-prefix adder with signed overflow
module sat_accumulator_adder #(
  parameter int WIDTH = 25
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);
  logic [WIDTH-1:0] g, p;
  // prefix tree: after the last level g[i] is the carry out of bit i
  always_comb begin
    g = a & b;
    p = a ^ b;
    for (int k = 1; k < WIDTH; k = k * 2) begin
      for (int i = WIDTH - 1; i >= k; i--) begin
        g[i] = g[i] | (p[i] & g[i-k]);
        p[i] = p[i] & p[i-k];
      end
    end
  end
  assign sum = (a ^ b) ^ {g[WIDTH-2:0], 1'b0};
  assign ovf = g[WIDTH-1] ^ g[WIDTH-2];
endmodule

// File: rtl/sat_accumulator.sv
// sat_accumulator: packet-wise saturating signed accumulator with valid/ready in and out
module sat_accumulator import arith_pkg::*; #(
  parameter int WIDTH = arith_pkg::WIDTH,
  parameter int CNT_W = arith_pkg::CNT_W
) (
  input logic clk,
  input logic rst_n,
  sat_accumulator_if.slave bus
);
  state_e           state_d, state_q;
  logic [WIDTH-1:0] acc_d, acc_q, sum;
  logic             sat_d, sat_q, ovf;
  logic [CNT_W-1:0] count_d, count_q;
  logic             in_ready_d, in_ready_q, out_valid_d, out_valid_q;
  sat_accumulator_adder #(.WIDTH(WIDTH)) u_adder (
    .a(acc_q), .b(bus.in_data), .sum(sum), .ovf(ovf)
  );
  // next state: accumulate accepted samples, clear on result handshake
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    count_d = count_q;
    if (state_q == DONE) begin
      if (bus.out_ready) begin
        state_d = ACC;
        acc_d   = '0;
        sat_d   = 1'b0;
        count_d = '0;
      end
    end else if (bus.in_valid && in_ready_q) begin
      acc_d   = ovf ? (bus.in_data[WIDTH-1] ? SAT_MIN : SAT_MAX) : sum;
      sat_d   = sat_q | ovf;
      count_d = &count_q ? count_q : count_q + CNT_W'(1);
      state_d = bus.in_last ? DONE : ACC;
    end
    in_ready_d  = state_d == ACC;
    out_valid_d = state_d == DONE;
  end
  // registered FSM, datapath and handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = acc_q;
  assign bus.out_sat   = sat_q;
  assign bus.out_count = count_q;
endmodule

// File: tb/tb_sat_accumulator.sv
// tb_sat_accumulator: directed and random packets against an integer reference model
module tb_sat_accumulator;
  localparam int W = 25;
  localparam int CW = 8;
  localparam longint MAXV = (64'sd1 <<< (W - 1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (W - 1));
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  sat_accumulator_if #(.WIDTH(W), .CNT_W(CW)) bus ();
  sat_accumulator #(.WIDTH(W), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  int checks = 0;
  int errors = 0;
  longint m_acc;
  longint m_sat;
  longint m_cnt;
  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic longint sum_s();
    return longint'($signed(bus.out_sum));
  endfunction
  task automatic model_clear();
    m_acc = 0;
    m_sat = 0;
    m_cnt = 0;
  endtask
  task automatic model_add(input longint x);
    m_acc = m_acc + x;
    if (m_acc > MAXV) begin m_acc = MAXV; m_sat = 1; end
    if (m_acc < MINV) begin m_acc = MINV; m_sat = 1; end
    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
  endtask
  task automatic send(input longint x, input logic last);
    int n;
    logic [63:0] xv;
    xv = x;
    bus.in_valid = 1'b1;
    bus.in_data  = xv[W-1:0];
    bus.in_last  = last;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) chk("in_ready_timeout", longint'(bus.in_ready), 1);
    @(posedge clk);
    model_add(x);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask
  task automatic finish_pkt(input string tag, input int hold);
    longint s0;
    chk({tag, "_latency"}, longint'(bus.out_valid), 1);
    chk({tag, "_in_ready_low"}, longint'(bus.in_ready), 0);
    chk({tag, "_sum"}, sum_s(), m_acc);
    chk({tag, "_sat"}, longint'(bus.out_sat), m_sat);
    chk({tag, "_count"}, longint'(bus.out_count), m_cnt);
    s0 = sum_s();
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = W'($urandom);
      @(negedge clk);
      chk({tag, "_hold_valid"}, longint'(bus.out_valid), 1);
      chk({tag, "_hold_ready"}, longint'(bus.in_ready), 0);
      chk({tag, "_hold_sum"}, sum_s(), s0);
      chk({tag, "_hold_count"}, longint'(bus.out_count), m_cnt);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    model_clear();
    chk({tag, "_out_valid_drop"}, longint'(bus.out_valid), 0);
    chk({tag, "_in_ready_back"}, longint'(bus.in_ready), 1);
    chk({tag, "_sum_cleared"}, sum_s(), 0);
    chk({tag, "_count_cleared"}, longint'(bus.out_count), 0);
  endtask
  initial begin
    int len, hold;
    longint x;
    logic [W-1:0] rv;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    model_clear();
    #12;
    chk("rst_in_ready", longint'(bus.in_ready), 0);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_sum", sum_s(), 0);
    chk("rst_sat", longint'(bus.out_sat), 0);
    chk("rst_count", longint'(bus.out_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", longint'(bus.in_ready), 1);
    send(5, 1'b0);
    send(-3, 1'b0);
    send(10, 1'b1);
    chk("t1_sum_direct", sum_s(), 12);
    chk("t1_count_direct", longint'(bus.out_count), 3);
    finish_pkt("t1", 0);
    send(16777215, 1'b0);
    send(1, 1'b1);
    chk("t2_sum_direct", sum_s(), 16777215);
    chk("t2_sat_direct", longint'(bus.out_sat), 1);
    finish_pkt("t2", 0);
    send(-16777216, 1'b0);
    send(-1, 1'b0);
    chk("t3_mid_sum", sum_s(), -16777216);
    send(100, 1'b1);
    chk("t3_sum_direct", sum_s(), -16777116);
    finish_pkt("t3", 0);
    send(42, 1'b1);
    finish_pkt("t4", 5);
    send(7, 1'b1);
    chk("t4_next_from_zero", sum_s(), 7);
    finish_pkt("t4b", 0);
    bus.in_last = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.in_last = 1'b0;
    chk("idle_last_valid", longint'(bus.out_valid), 0);
    chk("idle_last_count", longint'(bus.out_count), 0);
    for (int i = 1; i <= 300; i++) send(1, i == 300);
    chk("t5_sum_direct", sum_s(), 300);
    chk("t5_count_direct", longint'(bus.out_count), 255);
    finish_pkt("t5", 0);
    send(7, 1'b0);
    send(8, 1'b0);
    chk("t6_partial", sum_s(), 15);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_sum", sum_s(), 0);
    chk("t6_rst_count", longint'(bus.out_count), 0);
    chk("t6_rst_in_ready", longint'(bus.in_ready), 0);
    chk("t6_rst_out_valid", longint'(bus.out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    send(4, 1'b1);
    chk("t6_sum_direct", sum_s(), 4);
    chk("t6_count_direct", longint'(bus.out_count), 1);
    finish_pkt("t6", 0);
    for (int p = 0; p < 20; p++) begin
      len  = $urandom_range(1, 6);
      hold = $urandom_range(0, 3);
      for (int s = 0; s < len; s++) begin
        rv = W'($urandom);
        x = ($urandom_range(0, 2) == 0) ? longint'($signed(rv)) : longint'($urandom_range(0, 2000)) - 1000;
        send(x, s == len - 1);
      end
      finish_pkt("rand", hold);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
